// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/RUN/HIT/OVER flow, bird-vs-tube/bound collision, best score.
// Optional macro SCORE_SPEED_EN enables the score-dependent scroll step output.
module game_flow_ctrl #(
    parameter int BIRD_X      = 200,
    parameter int BIRD_HALF   = 8,
    parameter int TUBE_HALF_W = 20,
    parameter int GAP_HALF    = 60,
    parameter int Y_TOP       = 0,
    parameter int Y_BOT       = 479,
    parameter int FLASH_TICKS = 16,
    parameter int GRACE       = 2
) (
    input  logic       clk_10,
    input  logic       clr,
    input  logic       btn_start,
    input  logic [9:0] bird_y,
    input  logic [9:0] x1,
    input  logic [9:0] y1,
    input  logic [9:0] x2,
    input  logic [9:0] y2,
    input  logic [9:0] x3,
    input  logic [9:0] y3,
    input  logic [9:0] score,
    output logic       over,
    output logic       tube_clr,
    output logic [1:0] state,
    output logic [2:0] hit_cause,
    output logic       flash,
    output logic [9:0] best_score,
    output logic [2:0] step
);

    localparam int FLASH_W = (FLASH_TICKS > 4) ? $clog2(FLASH_TICKS) : 2;
    localparam int GRACE_W = (GRACE > 0) ? $clog2(GRACE + 1) : 1;

    localparam logic signed [10:0] BX   = 11'(BIRD_X);
    localparam logic signed [10:0] BH   = 11'(BIRD_HALF);
    localparam logic signed [10:0] NEAR = 11'(TUBE_HALF_W + BIRD_HALF);
    localparam logic signed [10:0] GH   = 11'(GAP_HALF);
    localparam logic signed [10:0] YT   = 11'(Y_TOP);
    localparam logic signed [10:0] YB   = 11'(Y_BOT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_TUBE1 = 3'd1,
        C_TUBE2 = 3'd2,
        C_TUBE3 = 3'd3,
        C_BOUND = 3'd4
    } cause_t;

    state_t               state_q, state_d;
    cause_t               cause_q, cause_d, cur_cause;
    logic                 over_q, over_d;
    logic                 tclr_q, tclr_d;
    logic                 btn_prev;
    logic                 start_edge;
    logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic [GRACE_W-1:0]   grace_q, grace_d;
    logic [9:0]           best_q, best_d;

    // Tube i blocks the bird when horizontally overlapping and not fully inside the gap.
    function automatic logic tube_hit(input logic [9:0] xi, input logic [9:0] yi,
                                      input logic signed [10:0] by);
        logic signed [10:0] dx;
        logic signed [10:0] adx;
        logic signed [10:0] ty;
        logic               in_gap;
        dx     = BX - $signed({1'b0, xi});
        adx    = dx[10] ? -dx : dx;
        ty     = $signed({1'b0, yi});
        in_gap = (by - BH >= ty - GH) && (by + BH <= ty + GH);
        return (adx <= NEAR) && !in_gap;
    endfunction

    always_comb begin
        logic signed [10:0] by;
        by = $signed({1'b0, bird_y});
        if ((by - BH < YT) || (by + BH > YB)) cur_cause = C_BOUND;
        else if (tube_hit(x1, y1, by))        cur_cause = C_TUBE1;
        else if (tube_hit(x2, y2, by))        cur_cause = C_TUBE2;
        else if (tube_hit(x3, y3, by))        cur_cause = C_TUBE3;
        else                                  cur_cause = C_NONE;
    end

    assign start_edge = btn_start & ~btn_prev;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        over_d      = over_q;
        tclr_d      = 1'b0;
        cause_d     = cause_q;
        flash_cnt_d = '0;
        grace_d     = grace_q;
        best_d      = best_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_RUN;
                    tclr_d  = 1'b1;
                    over_d  = 1'b0;
                    grace_d = GRACE_W'(GRACE);
                end
            end
            S_RUN: begin
                if (grace_q != '0) begin
                    grace_d = grace_q - 1'b1;
                end else if (cur_cause != C_NONE) begin
                    state_d = S_HIT;
                    over_d  = 1'b1;
                    cause_d = cur_cause;
                end
            end
            S_HIT: begin
                if (flash_cnt_q == FLASH_W'(FLASH_TICKS - 1)) begin
                    state_d = S_OVER;
                    if (score > best_q) best_d = score;
                end else begin
                    flash_cnt_d = flash_cnt_q + 1'b1;
                end
            end
            S_OVER: begin
                if (start_edge) begin
                    state_d = S_RUN;
                    tclr_d  = 1'b1;
                    over_d  = 1'b0;
                    cause_d = C_NONE;
                    grace_d = GRACE_W'(GRACE);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_10 or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            over_q      <= 1'b1;
            tclr_q      <= 1'b0;
            cause_q     <= C_NONE;
            flash_cnt_q <= '0;
            grace_q     <= '0;
            best_q      <= '0;
            btn_prev    <= 1'b0;
        end else begin
            state_q     <= state_d;
            over_q      <= over_d;
            tclr_q      <= tclr_d;
            cause_q     <= cause_d;
            flash_cnt_q <= flash_cnt_d;
            grace_q     <= grace_d;
            best_q      <= best_d;
            btn_prev    <= btn_start;
        end
    end

`ifdef SCORE_SPEED_EN
    logic [2:0] step_q, step_d;

    // 1 + min(score/10, 3) expressed as threshold compares.
    always_comb begin
        step_d = step_q;
        if (state_q == S_RUN) begin
            if      (score >= 10'd30) step_d = 3'd4;
            else if (score >= 10'd20) step_d = 3'd3;
            else if (score >= 10'd10) step_d = 3'd2;
            else                      step_d = 3'd1;
        end else if (tclr_d) begin
            step_d = 3'd1;
        end
    end

    always_ff @(posedge clk_10 or posedge clr) begin
        if (clr) step_q <= 3'd1;
        else     step_q <= step_d;
    end

    assign step = step_q;
`else
    assign step = 3'd1;
`endif

    assign state      = state_q;
    assign over       = over_q;
    assign tube_clr   = tclr_q;
    assign hit_cause  = cause_q;
    assign flash      = (state_q == S_HIT) & flash_cnt_q[1];
    assign best_score = best_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed test-plan scenarios, then
// randomized play compared cycle by cycle against a behavioural model.
module tb_game_flow_ctrl;

    localparam int FLASH_TICKS = 16;
    localparam int GRACE       = 2;

`ifdef SCORE_SPEED_EN
    localparam int STEP_9  = 1;
    localparam int STEP_10 = 2;
    localparam int STEP_45 = 4;
`else
    localparam int STEP_9  = 1;
    localparam int STEP_10 = 1;
    localparam int STEP_45 = 1;
`endif

    logic       clk_10;
    logic       clr;
    logic       btn_start;
    logic [9:0] bird_y;
    logic [9:0] x1, y1, x2, y2, x3, y3;
    logic [9:0] score;
    logic       over;
    logic       tube_clr;
    logic [1:0] state;
    logic [2:0] hit_cause;
    logic       flash;
    logic [9:0] best_score;
    logic [2:0] step;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase 0 idle, 1 run, 2 hit, 3 over.
    int m_state, m_over, m_tclr, m_cause, m_cnt, m_grace, m_best, m_step, m_prev;

    game_flow_ctrl dut (
        .clk_10    (clk_10),
        .clr       (clr),
        .btn_start (btn_start),
        .bird_y    (bird_y),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .x3        (x3),
        .y3        (y3),
        .score     (score),
        .over      (over),
        .tube_clr  (tube_clr),
        .state     (state),
        .hit_cause (hit_cause),
        .flash     (flash),
        .best_score(best_score),
        .step      (step)
    );

    initial clk_10 = 1'b0;
    always #50 clk_10 = ~clk_10;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int speed_of(input int s);
        int q;
        q = s / 10;
        if (q > 3) q = 3;
        return 1 + q;
    endfunction

    function automatic int cause_now();
        int by;
        int xs[3];
        int ys[3];
        int dx;
        by = int'(bird_y);
        xs = '{int'(x1), int'(x2), int'(x3)};
        ys = '{int'(y1), int'(y2), int'(y3)};
        if (by - 8 < 0 || by + 8 > 479) return 4;
        for (int i = 0; i < 3; i++) begin
            dx = 200 - xs[i];
            if (dx < 0) dx = -dx;
            if (dx <= 28 && !(by - 8 >= ys[i] - 60 && by + 8 <= ys[i] + 60)) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_over = 1; m_tclr = 0; m_cause = 0; m_cnt = 0;
        m_grace = 0; m_best = 0; m_step = 1; m_prev = 0;
    endtask

    task automatic model_advance();
        int e, c;
        int n_state, n_over, n_tclr, n_cause, n_cnt, n_grace, n_best, n_step;
        e = (btn_start && !m_prev) ? 1 : 0;
        n_state = m_state; n_over = m_over; n_tclr = 0; n_cause = m_cause;
        n_cnt = 0; n_grace = m_grace; n_best = m_best; n_step = m_step;
        if ((m_state == 0 || m_state == 3) && e == 1) begin
            n_state = 1; n_tclr = 1; n_over = 0; n_grace = GRACE; n_cause = 0; n_step = 1;
        end else if (m_state == 1) begin
`ifdef SCORE_SPEED_EN
            n_step = speed_of(int'(score));
`endif
            if (m_grace > 0) begin
                n_grace = m_grace - 1;
            end else begin
                c = cause_now();
                if (c != 0) begin
                    n_state = 2; n_over = 1; n_cause = c;
                end
            end
        end else if (m_state == 2) begin
            if (m_cnt == FLASH_TICKS - 1) begin
                n_state = 3;
                if (int'(score) > m_best) n_best = int'(score);
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        m_state = n_state; m_over = n_over; m_tclr = n_tclr; m_cause = n_cause;
        m_cnt = n_cnt; m_grace = n_grace; m_best = n_best; m_step = n_step;
        m_prev = btn_start ? 1 : 0;
    endtask

    task automatic check_all();
        check("state", int'(state), m_state);
        check("over", int'(over), m_over);
        check("tube_clr", int'(tube_clr), m_tclr);
        check("hit_cause", int'(hit_cause), m_cause);
        check("flash", int'(flash), (m_state == 2 && ((m_cnt >> 1) & 1) == 1) ? 1 : 0);
        check("best_score", int'(best_score), m_best);
        check("step", int'(step), m_step);
    endtask

    // One clock: model consumes the pre-edge inputs, DUT outputs sampled 1 time unit later.
    task automatic tick();
        model_advance();
        @(posedge clk_10);
        #1;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_over"}, int'(over), 1);
        check({tag, "_tube_clr"}, int'(tube_clr), 0);
        check({tag, "_cause"}, int'(hit_cause), 0);
        check({tag, "_flash"}, int'(flash), 0);
        check({tag, "_best"}, int'(best_score), 0);
        check({tag, "_step"}, int'(step), 1);
    endtask

    initial begin
        clr = 1'b1; btn_start = 1'b0; bird_y = 10'd240; score = 10'd0;
        x1 = 10'd700; y1 = 10'd240; x2 = 10'd700; y2 = 10'd240; x3 = 10'd700; y3 = 10'd240;
        model_reset();
        #20;
        check_reset_values("reset");
        @(negedge clk_10);
        clr = 1'b0;

        // Start pulse, held button gives no second pulse.
        btn_start = 1'b1;
        tick();
        check("start_pulse", int'(tube_clr), 1);
        check("start_state", int'(state), 1);
        check("start_over", int'(over), 0);
        tick();
        check("held_no_pulse", int'(tube_clr), 0);
        repeat (2) tick();

        // Tube 1 centred on the bird column.
        x1 = 10'd200; y1 = 10'd240; bird_y = 10'd240;
        repeat (3) tick();
        check("in_gap_no_hit", int'(state), 1);
        score = 10'd9;  tick(); check("step_9", int'(step), STEP_9);
        score = 10'd10; tick(); check("step_10", int'(step), STEP_10);
        score = 10'd45; tick(); check("step_45", int'(step), STEP_45);
        score = 10'd7;
        bird_y = 10'd175;
        tick();
        check("tube1_hit_state", int'(state), 2);
        check("tube1_hit_cause", int'(hit_cause), 1);
        check("tube1_hit_over", int'(over), 1);

        // HIT lasts FLASH_TICKS cycles; button edges ignored.
        for (int i = 1; i < FLASH_TICKS; i++) begin
            btn_start = i[0];
            tick();
        end
        check("hit_still_hit", int'(state), 2);
        btn_start = 1'b0;
        tick();
        check("over_after_16", int'(state), 3);
        check("best_7", int'(best_score), 7);

        // Restart into a bound collision held during the grace window.
        x1 = 10'd700; bird_y = 10'd472;
        tick();
        btn_start = 1'b1;
        tick();
        check("restart_cause_clear", int'(hit_cause), 0);
        check("restart_pulse", int'(tube_clr), 1);
        tick(); check("grace_1", int'(state), 1);
        tick(); check("grace_2", int'(state), 1);
        bird_y = 10'd471;
        tick(); check("bound_471_no_hit", int'(state), 1);
        bird_y = 10'd472; x2 = 10'd200; y2 = 10'd240;
        tick();
        check("bound_priority", int'(hit_cause), 4);
        score = 10'd5;
        repeat (FLASH_TICKS) tick();
        check("over_again", int'(state), 3);
        check("best_kept_7", int'(best_score), 7);

        // Horizontal reach edge: 229 misses, 228 hits.
        btn_start = 1'b0; x2 = 10'd700; bird_y = 10'd175; x1 = 10'd229; y1 = 10'd240;
        tick();
        btn_start = 1'b1;
        tick();
        repeat (2) tick();
        tick(); check("x229_no_hit", int'(state), 1);
        x1 = 10'd228;
        tick();
        check("x228_hit", int'(hit_cause), 1);
        repeat (2) tick();
        check("flash_on", int'(flash), 1);

        // Asynchronous clear mid-HIT.
        #5 clr = 1'b1;
        #1;
        check_reset_values("clr_in_hit");
        model_reset();
        @(negedge clk_10);
        clr = 1'b0;
        btn_start = 1'b0;

        // Randomized play against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 3) == 0) bird_y = 10'($urandom_range(0, 479));
            else                           bird_y = 10'($urandom_range(190, 290));
            x1 = 10'($urandom_range(0, 800)); y1 = 10'($urandom_range(150, 330));
            x2 = 10'($urandom_range(0, 800)); y2 = 10'($urandom_range(150, 330));
            x3 = 10'($urandom_range(0, 800)); y3 = 10'($urandom_range(150, 330));
            score = 10'($urandom_range(0, 60));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
